// File: rtl/zynet_pkg.sv
// Shared types and sizing helpers for the zyNet input streaming blocks.
package zynet_pkg;

    localparam int ZYNET_WORD_SIZE = 16;

    typedef logic signed [ZYNET_WORD_SIZE-1:0] word_t;

    function automatic int serializer_beats(input int vector_len, input int pad, input int lanes);
        return (vector_len + 2 * pad) / lanes;
    endfunction

    function automatic int serializer_idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/vector_pingpong_buf.sv
// Two-entry vector store: upstream fills one slot while the other is being streamed out.
module vector_pingpong_buf
    import zynet_pkg::*;
#(
    parameter int VECTOR_LEN = 256,
    parameter int WORD_SIZE  = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [VECTOR_LEN*WORD_SIZE-1:0]  data_i,
    input  logic                             pop_i,
    output logic                             not_empty_o,
    output logic [VECTOR_LEN*WORD_SIZE-1:0]  rd_data_o
);

    localparam int VW = VECTOR_LEN * WORD_SIZE;

    logic [VW-1:0] buf0_q, buf0_d;
    logic [VW-1:0] buf1_q, buf1_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [1:0]    count_q, count_d;
    logic          accept;

    assign ready_o     = reset_n_i && (count_q != 2'd2);
    assign accept      = valid_i && ready_o;
    assign not_empty_o = (count_q != 2'd0);
    assign rd_data_o   = rd_sel_q ? buf1_q : buf0_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        count_d  = count_q;
        if (accept) begin
            if (wr_sel_q) buf1_d = data_i;
            else          buf0_d = data_i;
            wr_sel_d = ~wr_sel_q;
        end
        if (pop_i) begin
            rd_sel_d = ~rd_sel_q;
        end
        case ({accept, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            // NOTE: the vector slots are cleared too, so a reset never leaves an old vector readable.
            buf0_q   <= '0;
            buf1_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vector_serializer.sv
// Streams a buffered VECTOR_LEN-word vector out LANES words per beat, with optional zero padding.
module vector_serializer
    import zynet_pkg::*;
#(
    parameter int VECTOR_LEN = 256,
    parameter int WORD_SIZE  = 16,
    parameter int LANES      = 1,
    parameter int PAD        = 0,
    parameter int MSB_FIRST  = 0
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [VECTOR_LEN*WORD_SIZE-1:0]  data_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [LANES*WORD_SIZE-1:0]       data_o,
    output logic                             first_o,
    output logic                             last_o
);

    localparam int TOTAL = VECTOR_LEN + 2 * PAD;
    localparam int BEATS = serializer_beats(VECTOR_LEN, PAD, LANES);
    localparam int IDX_W = serializer_idx_width(BEATS);

    if (TOTAL % LANES != 0) begin : g_bad_lanes
        $error("vector_serializer: VECTOR_LEN+2*PAD must be a multiple of LANES");
    end

    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [VECTOR_LEN*WORD_SIZE-1:0] rd_data;
    logic                            transfer;
    logic                            last_beat;

    assign transfer  = valid_o && ready_i;
    assign last_beat = (idx_q == IDX_W'(BEATS - 1));

    vector_pingpong_buf #(
        .VECTOR_LEN (VECTOR_LEN),
        .WORD_SIZE  (WORD_SIZE)
    ) u_buf (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .pop_i       (transfer && last_beat),
        .not_empty_o (valid_o),
        .rd_data_o   (rd_data)
    );

    always_comb begin
        idx_d = idx_q;
        if (transfer) begin
            idx_d = last_beat ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) idx_q <= '0;
        else            idx_q <= idx_d;
    end

    // Stream position p selects a pad zero or a buffered word in the chosen order.
    always_comb begin
        int p;
        int q;
        p       = 0;
        q       = 0;
        data_o  = '0;
        first_o = 1'b0;
        last_o  = 1'b0;
        if (valid_o) begin
            first_o = (idx_q == '0);
            last_o  = last_beat;
            for (int k = 0; k < LANES; k++) begin
                p = int'(idx_q) * LANES + k;
                if (p >= PAD && p < PAD + VECTOR_LEN) begin
                    q = (MSB_FIRST != 0) ? (VECTOR_LEN - 1 - (p - PAD)) : (p - PAD);
                    data_o[k*WORD_SIZE +: WORD_SIZE] = rd_data[q*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Randomised and directed checks of vector_serializer in three lane/pad/order configurations.
module tb_vector_serializer;

    localparam int VL = 4;
    localparam int W  = 16;

    logic clk;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int LANES = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int PAD   = (g == 1) ? 2 : 0;
        localparam int MSB   = (g == 1) ? 1 : 0;
        localparam int TOTAL = VL + 2 * PAD;
        localparam int BEATS = TOTAL / LANES;
        localparam int RB    = (BEATS > 2) ? 2 : 0;

        logic                 rst_n;
        logic                 valid_i;
        logic                 ready_o;
        logic [VL*W-1:0]      data_i;
        logic                 valid_o;
        logic                 ready_i;
        logic [LANES*W-1:0]   data_o;
        logic                 first_o;
        logic                 last_o;
        bit                   done;

        vector_serializer #(
            .VECTOR_LEN (VL),
            .WORD_SIZE  (W),
            .LANES      (LANES),
            .PAD        (PAD),
            .MSB_FIRST  (MSB)
        ) dut (
            .clk_i     (clk),
            .reset_n_i (rst_n),
            .valid_i   (valid_i),
            .ready_o   (ready_o),
            .data_i    (data_i),
            .valid_o   (valid_o),
            .ready_i   (ready_i),
            .data_o    (data_o),
            .first_o   (first_o),
            .last_o    (last_o)
        );

        // Reference: FIFO of whole accepted vectors (capacity two) plus a beat number within the head.
        logic [VL*W-1:0] vq[$];
        int              beat;
        bit              last_acc;

        always @(posedge clk) begin : model
            bit acc;
            bit xfer;
            if (!rst_n) begin
                vq.delete();
                beat     = 0;
                last_acc = 0;
            end else begin
                acc  = valid_i && (vq.size() < 2);
                xfer = (vq.size() != 0) && ready_i;
                if (xfer) begin
                    if (beat == BEATS - 1) begin
                        void'(vq.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                if (acc) vq.push_back(data_i);
                last_acc = acc;
            end
        end

        always @(negedge clk) begin : monitor
            logic [15:0]        stream [TOTAL];
            logic [LANES*W-1:0] exp_data;
            bit                 has;
            has      = (vq.size() != 0);
            exp_data = '0;
            if (has) begin
                for (int i = 0; i < TOTAL; i++) stream[i] = 16'h0;
                for (int i = 0; i < VL; i++)
                    stream[PAD + i] = vq[0][((MSB != 0) ? (VL - 1 - i) : i) * W +: W];
                for (int k = 0; k < LANES; k++)
                    exp_data[k*W +: W] = stream[beat * LANES + k];
            end
            check($sformatf("c%0d_ready", g), ready_o, rst_n && (vq.size() < 2));
            check($sformatf("c%0d_valid", g), valid_o, has);
            check($sformatf("c%0d_first", g), first_o, has && (beat == 0));
            check($sformatf("c%0d_last",  g), last_o,  has && (beat == BEATS - 1));
            check($sformatf("c%0d_data",  g), data_o,  exp_data);
        end

        task automatic send(input logic [VL*W-1:0] v);
            int n;
            valid_i = 1'b1;
            data_i  = v;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!last_acc && n < 100);
            if (!last_acc) check($sformatf("c%0d_send_timeout", g), last_acc, 1'b1);
        endtask

        task automatic wait_beat(input int b);
            int n;
            n = 0;
            while (beat != b && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (beat != b) check($sformatf("c%0d_beat_timeout", g), beat, b);
        endtask

        task automatic wait_drain();
            int n;
            n = 0;
            while (vq.size() != 0 && n < 400) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (vq.size() != 0) check($sformatf("c%0d_drain_timeout", g), vq.size(), 0);
        endtask

        initial begin : driver
            done    = 0;
            rst_n   = 1'b0;
            valid_i = 1'b0;
            ready_i = 1'b0;
            data_i  = '0;
            repeat (2) @(posedge clk);
            #1;
            rst_n   = 1'b1;
            ready_i = 1'b1;

            send(64'h0004_0003_0002_0001);
            valid_i = 1'b0;
            wait_drain();

            send({$urandom, $urandom});
            valid_i = 1'b0;
            wait_beat(RB);
            ready_i = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            ready_i = 1'b1;
            wait_drain();

            send({$urandom, $urandom});
            send({$urandom, $urandom});
            send({$urandom, $urandom});
            valid_i = 1'b0;
            wait_drain();

            send(64'haaaa_bbbb_cccc_dddd);
            send(64'h1111_2222_3333_4444);
            valid_i = 1'b0;
            wait_beat(RB);
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            send(64'h0c0c_0b0b_0a0a_0909);
            valid_i = 1'b0;
            wait_drain();

            for (int i = 0; i < 400; i++) begin
                @(posedge clk);
                #1;
                valid_i = ($urandom_range(0, 2) != 0);
                data_i  = {$urandom, $urandom};
                ready_i = ($urandom_range(0, 3) != 0);
                rst_n   = ($urandom_range(0, 99) != 0);
            end
            valid_i = 1'b0;
            ready_i = 1'b1;
            rst_n   = 1'b1;
            wait_drain();
            repeat (2) @(posedge clk);
            done = 1;
        end
    end

    initial begin : supervisor
        int n;
        checks   = 0;
        failures = 0;
        n        = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done))
            check("run_timeout", {g_cfg[2].done, g_cfg[1].done, g_cfg[0].done}, 3'b111);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
